// File: rtl/scoreboard_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | scoreboard_pkg : error codes and FSM states for stream_scoreboard  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package scoreboard_pkg;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_MISMATCH  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    FAIL = 1'b1
  } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/sb_sync_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | sb_sync_fifo : WIDTH x DEPTH synchronous FIFO, no bypass           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | stream_scoreboard : in-order expected/actual compare with sticky ok |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module stream_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exp_valid,
  input  logic [WIDTH-1:0]         exp_data,
  output logic                     exp_ready,
  input  logic                     act_valid,
  input  logic [WIDTH-1:0]         act_data,
  output logic                     ok,
  output logic [1:0]               err_code,
  output logic [WIDTH-1:0]         err_exp,
  output logic [WIDTH-1:0]         err_act,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sb_state_t        r_state, w_state_n;
  logic             r_ok, w_ok_n;
  logic [1:0]       r_code, w_code_n;
  logic [WIDTH-1:0] r_exp, w_exp_n;
  logic [WIDTH-1:0] r_act, w_act_n;
  logic [CNT_W-1:0] r_match, w_match_n;
  logic [TW-1:0]    r_tcnt;

  logic [WIDTH-1:0]         w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(DEPTH):0]   w_count;
  logic                     w_push, w_pop, w_idle;
  logic                     w_underflow, w_mismatch, w_match, w_timeout;

  sb_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (exp_data),
    .pop     (w_pop),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign w_push      = exp_valid & ~w_full;
  assign w_pop       = act_valid & ~w_empty;
  assign w_idle      = ~w_empty & ~act_valid;
  assign w_underflow = act_valid & w_empty;
  assign w_mismatch  = w_pop & (act_data != w_head);
  assign w_match     = w_pop & (act_data == w_head);
  // Fires on the TIMEOUT-th consecutive idle cycle; the counter holds prior ones.
  assign w_timeout   = w_idle & (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (!w_idle) begin
      r_tcnt <= '0;
    end else if (r_tcnt != TW'(TIMEOUT)) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_ok    <= 1'b1;
      r_code  <= ERR_NONE;
      r_exp   <= '0;
      r_act   <= '0;
      r_match <= '0;
    end else begin
      r_state <= w_state_n;
      r_ok    <= w_ok_n;
      r_code  <= w_code_n;
      r_exp   <= w_exp_n;
      r_act   <= w_act_n;
      r_match <= w_match_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ok_n    = r_ok;
    w_code_n  = r_code;
    w_exp_n   = r_exp;
    w_act_n   = r_act;
    w_match_n = r_match;
    case (r_state)
      RUN: begin
        if (w_underflow) begin
          w_state_n = FAIL;
          w_ok_n    = 1'b0;
          w_code_n  = ERR_UNDERFLOW;
          w_exp_n   = '0;
          w_act_n   = act_data;
        end else if (w_mismatch) begin
          w_state_n = FAIL;
          w_ok_n    = 1'b0;
          w_code_n  = ERR_MISMATCH;
          w_exp_n   = w_head;
          w_act_n   = act_data;
        end else if (w_timeout) begin
          w_state_n = FAIL;
          w_ok_n    = 1'b0;
          w_code_n  = ERR_TIMEOUT;
          w_exp_n   = '0;
          w_act_n   = '0;
        end else if (w_match && (r_match != {CNT_W{1'b1}})) begin
          w_match_n = r_match + 1'b1;
        end
      end
      FAIL: begin
        // Diagnostics frozen; only rst leaves this state.
        w_state_n = FAIL;
      end
      default: begin
        w_state_n = FAIL;
        w_ok_n    = 1'b0;
      end
    endcase
  end

  assign exp_ready   = ~w_full;
  assign pending     = w_count;
  assign ok          = r_ok;
  assign err_code    = r_code;
  assign err_exp     = r_exp;
  assign err_act     = r_act;
  assign match_count = r_match;

endmodule
`default_nettype wire

// File: tb/tb_stream_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_stream_scoreboard : random + directed bench with queue model    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_stream_scoreboard;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             exp_valid = 1'b0;
  logic [WIDTH-1:0] exp_data = '0;
  logic             exp_ready;
  logic             act_valid = 1'b0;
  logic [WIDTH-1:0] act_data = '0;
  logic             ok;
  logic [1:0]       err_code;
  logic [WIDTH-1:0] err_exp;
  logic [WIDTH-1:0] err_act;
  logic [CNT_W-1:0] match_count;
  logic [4:0]       pending;

  int n_checks = 0;
  int n_err    = 0;

  stream_scoreboard #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exp_valid   (exp_valid),
    .exp_data    (exp_data),
    .exp_ready   (exp_ready),
    .act_valid   (act_valid),
    .act_data    (act_data),
    .ok          (ok),
    .err_code    (err_code),
    .err_exp     (err_exp),
    .err_act     (err_act),
    .match_count (match_count),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: a plain queue plus a latched first-error record.
  logic [WIDTH-1:0] q[$];
  bit               m_init = 0;
  bit               m_ok;
  int               m_code, m_exp, m_act, m_cnt, m_idle;
  int               e_code, e_exp, e_act;
  bit               matched, do_push;
  logic [WIDTH-1:0] m_head;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ok = 1; m_code = 0; m_exp = 0; m_act = 0; m_cnt = 0; m_idle = 0;
      m_init = 1;
    end else if (m_init) begin
      do_push = exp_valid && (q.size() < DEPTH);
      e_code = 0; e_exp = 0; e_act = 0; matched = 0;
      if (act_valid) begin
        m_idle = 0;
        if (q.size() == 0) begin
          e_code = 2; e_act = int'(act_data);
        end else begin
          m_head = q.pop_front();
          if (m_head == act_data) matched = 1;
          else begin e_code = 1; e_exp = int'(m_head); e_act = int'(act_data); end
        end
      end else if (q.size() != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) e_code = 3;
      end else begin
        m_idle = 0;
      end
      if (m_ok) begin
        if (e_code != 0) begin
          m_ok = 0; m_code = e_code; m_exp = e_exp; m_act = e_act;
        end else if (matched && m_cnt < (1 << CNT_W) - 1) begin
          m_cnt++;
        end
      end
      if (do_push) q.push_back(exp_data);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("ok",          32'(ok),          32'(m_ok));
      check("err_code",    32'(err_code),    32'(m_code));
      check("err_exp",     32'(err_exp),     32'(m_exp));
      check("err_act",     32'(err_act),     32'(m_act));
      check("match_count", 32'(match_count), 32'(m_cnt));
      check("pending",     32'(pending),     32'(q.size()));
      check("exp_ready",   32'(exp_ready),   32'(q.size() < DEPTH));
    end
  end

  task automatic cycle(input logic ev, input logic [WIDTH-1:0] ed,
                       input logic av, input logic [WIDTH-1:0] ad);
    exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] rd;
  int stall;

  initial begin
    do_reset();
    do_reset();
    check("rst_ok",      32'(ok), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ready",   32'(exp_ready), 32'd1);
    check("rst_match",   32'(match_count), 32'd0);

    // In-order matches
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    cycle(0, 0, 1, 8'h11);
    cycle(0, 0, 1, 8'h22);
    cycle(0, 0, 1, 8'h33);
    check("seq_match",   32'(match_count), 32'd3);
    check("seq_pending", 32'(pending), 32'd0);
    check("seq_ok",      32'(ok), 32'd1);

    // Mismatch latch, then a later match must not count
    cycle(1, 8'hA5, 0, 0);
    cycle(0, 0, 1, 8'hA4);
    check("mis_ok",   32'(ok), 32'd0);
    check("mis_code", 32'(err_code), 32'd1);
    check("mis_exp",  32'(err_exp), 32'hA5);
    check("mis_act",  32'(err_act), 32'hA4);
    cycle(1, 8'h01, 0, 0);
    cycle(0, 0, 1, 8'h01);
    check("mis_frozen", 32'(match_count), 32'd3);

    do_reset();
    check("rst2_ok",    32'(ok), 32'd1);
    check("rst2_code",  32'(err_code), 32'd0);
    check("rst2_match", 32'(match_count), 32'd0);

    // Same-cycle push does not satisfy the beat
    cycle(1, 8'h7E, 1, 8'h7E);
    check("und_code",    32'(err_code), 32'd2);
    check("und_exp",     32'(err_exp), 32'd0);
    check("und_act",     32'(err_act), 32'h7E);
    check("und_pending", 32'(pending), 32'd1);

    // Timeout on the 64th idle cycle
    do_reset();
    cycle(1, 8'h5C, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 0, 0);
    check("to63_ok", 32'(ok), 32'd1);
    cycle(0, 0, 0, 0);
    check("to64_ok",   32'(ok), 32'd0);
    check("to64_code", 32'(err_code), 32'd3);
    do_reset();
    cycle(1, 8'h5D, 0, 0);
    for (int i = 0; i < TIMEOUT - 2; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 8'h5D);
    for (int i = 0; i < 80; i++) cycle(0, 0, 0, 0);
    check("to_save_ok",    32'(ok), 32'd1);
    check("to_save_match", 32'(match_count), 32'd1);

    // Full, refused push with simultaneous pop, then wrap-around
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    check("full_ready",   32'(exp_ready), 32'd0);
    check("full_pending", 32'(pending), 32'd16);
    cycle(1, 8'hEE, 1, 8'h40);
    check("full_pp_pending", 32'(pending), 32'd15);
    for (int i = 0; i < 40; i++) cycle(1, 8'(8'h80 + i), 1, q[0]);
    check("wrap_ok",      32'(ok), 32'd1);
    check("wrap_match",   32'(match_count), 32'd41);
    check("wrap_pending", 32'(pending), 32'd15);

    // Randomised traffic with occasional corruption, stalls and resets
    do_reset();
    stall = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if (stall == 0 && $urandom_range(0, 299) == 0) stall = $urandom_range(55, 75);
        rd = 8'($urandom);
        if (q.size() != 0 && $urandom_range(0, 59) != 0) rd = q[0];
        if (stall > 0) begin
          stall--;
          cycle(1'($urandom_range(0, 1)), 8'($urandom), 0, 0);
        end else begin
          cycle(1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 2) == 0), rd);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_scoreboard.md
Name: stream_scoreboard

Overview:
Simulation-side checker that sits directly upstream of the one-bit assertion monitor and drives that monitor's test input.
- Golden model pushes expected words into an in-order queue.
- DUT output beats are popped and compared against the queue head.
- Any mismatch, underflow or stall timeout drops the sticky `ok` output, so the downstream assert halts the simulation on the next clock.
- Also exposes the error cause and the offending data for debug.

Parameters:
WIDTH, 8, bit width of compared data words
DEPTH, 16, expected-queue entries (power of two, >=2)
TIMEOUT, 64, max consecutive cycles with a non-empty queue and no actual beat before a timeout error
CNT_W, 16, width of the match counter

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
exp_valid  input  1  expected word offered
exp_data  input  WIDTH  expected word
exp_ready  output  1  queue can accept (= not full)
act_valid  input  1  DUT output beat present this cycle (no backpressure)
act_data  input  WIDTH  DUT output word
ok  output  1  registered; 1 while no error has occurred; feeds assert test
err_code  output  2  0 none, 1 mismatch, 2 underflow, 3 timeout
err_exp  output  WIDTH  queue head at first error (0 for underflow and timeout)
err_act  output  WIDTH  act_data at first error (0 for timeout)
match_count  output  CNT_W  number of matched beats, saturating
pending  output  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset: synchronous, active-high; clk and rst are the only clock and reset.
  - On any clk edge with rst=1: queue emptied, pointers and timeout counter zeroed.
  - Outputs after reset: ok=1, err_code=0, err_exp=0, err_act=0, match_count=0, pending=0, exp_ready=1.
  - ok must read 1 throughout reset so the downstream assert does not fire.
  - Reset mid-operation discards all queued entries and clears any latched error.
- Push: occurs when exp_valid && exp_ready. Writes the tail; pending increments next cycle.
- Full: exp_ready=0 when pending==DEPTH, even if a pop happens in the same cycle. No bypass.
- Compare: on act_valid, act_data is checked against the registered head.
  - Pending>0 and equal: pop, match_count+1 (holds at 2^CNT_W-1).
  - Pending>0 and not equal: pop, mismatch error.
  - Pending==0: underflow error. A push in the same cycle does not satisfy the beat.
  - Simultaneous push and pop with 0<pending<DEPTH leaves pending unchanged.
- Timeout counter:
  - Clears on act_valid or when pending==0.
  - Otherwise increments each cycle.
  - Timeout error when it reaches TIMEOUT, i.e. the TIMEOUT-th idle cycle.
- Error latching:
  - State machine: RUN -> FAIL on the first error. FAIL exits only through rst.
  - In FAIL: err_code, err_exp and err_act frozen; match_count frozen; the queue keeps accepting and popping.
  - ok and err_* update on the edge that samples the offending beat, i.e. one cycle latency. The assert trips on the following edge.
  - Same-cycle priority: underflow > mismatch > timeout.
- Pointer arithmetic: log2(DEPTH)-bit pointers wrap modulo DEPTH. Occupancy is tracked with an extra bit.

Decomposition:
- Package scoreboard_pkg: error-code localparams ERR_NONE, ERR_MISMATCH, ERR_UNDERFLOW, ERR_TIMEOUT; state encoding RUN/FAIL.
- One sub-module, sb_sync_fifo: the parameterised WIDTH x DEPTH synchronous FIFO.
  - Outputs: head, full, empty, count.
  - Inputs: push, pop.
- Compare, timeout and error FSM live in the top.

Test Plan:
- Push 0x11,0x22,0x33; then act 0x11,0x22,0x33 on consecutive cycles -> ok=1 throughout, match_count=3, pending=0.
- Push 0xA5; act 0xA4 -> next edge ok=0, err_code=1, err_exp=0xA5, err_act=0xA4; later matches leave match_count unchanged.
- Empty queue, act_valid with 0x7E while exp_valid pushes 0x7E in the same cycle -> err_code=2, err_exp=0, err_act=0x7E.
- Push one word, no act for 64 cycles -> ok stays 1 through cycle 63, err_code=3 at cycle 64. A run with act on cycle 63 -> no error.
- Push 16 words with no act -> exp_ready=0, pending=16. Push+act in the same cycle -> push refused, pending=15. Wrap-around: 40 interleaved push/pop -> all match.
- Mismatch latched, then rst high for one cycle -> ok=1, err_code=0, pending=0, match_count=0. A subsequent clean sequence passes.
